// File: rtl/aes_v2_sbox_arbiter.sv
// Shares one external combinational AES S-box between two word-level SubBytes requesters.
// Each granted word is pushed through the S-box one byte per cycle and packed into a 32-bit result.
module aes_v2_sbox_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        a_valid,
  input  logic [31:0] a_rs1,
  input  logic [31:0] a_rs2,
  input  logic        a_enc,
  input  logic        a_rot,
  output logic        a_ready,
  output logic [31:0] a_rd,
  input  logic        b_valid,
  input  logic [31:0] b_rs1,
  input  logic [31:0] b_rs2,
  input  logic        b_enc,
  input  logic        b_rot,
  output logic        b_ready,
  output logic [31:0] b_rd,
  output logic [7:0]  sbox_in,
  output logic        sbox_inv,
  input  logic [7:0]  sbox_out,
  output logic        busy,
  output logic        grant
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_reg;
  logic [1:0]  step_reg;
  logic        grant_reg;
  logic        last_grant_reg;
  logic [7:0]  b0_reg;
  logic [7:0]  b1_reg;
  logic [7:0]  b2_reg;

  logic        grant_next;
  logic        sel_valid;
  logic [31:0] sel_rs1;
  logic [31:0] sel_rs2;
  logic        sel_enc;
  logic        sel_rot;
  logic        in_run;
  logic        done;
  logic [31:0] result;
  logic [3:0][7:0] step_byte;

  // With a single requester it wins outright; on contention the parameter picks the policy.
  assign grant_next = b_valid & (~a_valid | (PRIO_FIXED ? 1'b0 : ~last_grant_reg));

  assign sel_valid = grant_reg ? b_valid : a_valid;
  assign sel_rs1   = grant_reg ? b_rs1   : a_rs1;
  assign sel_rs2   = grant_reg ? b_rs2   : a_rs2;
  assign sel_enc   = grant_reg ? b_enc   : a_enc;
  assign sel_rot   = grant_reg ? b_rot   : a_rot;

  // Even steps take their byte from rs1, odd steps from rs2, at the lane matching the step.
  for (genvar gi = 0; gi < 4; gi++) begin : g_step_byte
    if (gi % 2 == 0) begin : g_rs1
      assign step_byte[gi] = sel_rs1[8*gi +: 8];
    end else begin : g_rs2
      assign step_byte[gi] = sel_rs2[8*gi +: 8];
    end
  end

  assign in_run   = (state_reg == RUN);
  assign sbox_in  = in_run ? step_byte[step_reg] : 8'h00;
  assign sbox_inv = in_run & ~sel_enc;
  assign busy     = in_run;
  assign grant    = grant_reg;

  // The last byte comes straight from the S-box, so the result is ready in the step-3 cycle.
  assign done   = in_run & (step_reg == 2'd3) & sel_valid;
  assign result = sel_rot ? {b2_reg, b1_reg, b0_reg, sbox_out}
                          : {sbox_out, b2_reg, b1_reg, b0_reg};

  assign a_ready = done & ~grant_reg;
  assign b_ready = done &  grant_reg;
  assign a_rd    = a_ready ? result : 32'h0000_0000;
  assign b_rd    = b_ready ? result : 32'h0000_0000;

  always_ff @(posedge g_clk) begin
    if (g_resetn) begin
      state_reg      <= IDLE;
      step_reg       <= 2'd0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      b0_reg         <= 8'h00;
      b1_reg         <= 8'h00;
      b2_reg         <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (a_valid | b_valid) begin
            state_reg <= RUN;
            step_reg  <= 2'd0;
            grant_reg <= grant_next;
          end
        end
        RUN: begin
          if (!sel_valid) begin
            // Owner withdrew: drop the job silently and keep the fairness history.
            state_reg <= IDLE;
            step_reg  <= 2'd0;
          end else begin
            step_reg <= step_reg + 2'd1;
            case (step_reg)
              2'd0: b0_reg <= sbox_out;
              2'd1: b1_reg <= sbox_out;
              2'd2: b2_reg <= sbox_out;
              default: begin
                last_grant_reg <= grant_reg;
                state_reg      <= IDLE;
              end
            endcase
          end
        end
        default: begin
          state_reg <= IDLE;
          step_reg  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_v2_sbox_arbiter.sv
// Directed bench for the shared S-box arbiter: one round-robin instance and one fixed-priority
// instance driven by the same requesters, each with its own behavioural S-box.
module tb_aes_v2_sbox_arbiter;

  logic        g_clk;
  logic        g_resetn;
  logic        a_valid, a_enc, a_rot;
  logic [31:0] a_rs1, a_rs2;
  logic        b_valid, b_enc, b_rot;
  logic [31:0] b_rs1, b_rs2;

  logic        a_ready_rr, b_ready_rr, sbox_inv_rr, busy_rr, grant_rr;
  logic [31:0] a_rd_rr, b_rd_rr;
  logic [7:0]  sbox_in_rr, sbox_out_rr;
  logic        a_ready_fx, b_ready_fx, sbox_inv_fx, busy_fx, grant_fx;
  logic [31:0] a_rd_fx, b_rd_fx;
  logic [7:0]  sbox_in_fx, sbox_out_fx;

  logic [7:0]  fwd_tab [256];
  logic [7:0]  inv_tab [256];

  int assert_cnt = 0;
  int fail_cnt   = 0;

  assign sbox_out_rr = sbox_inv_rr ? inv_tab[sbox_in_rr] : fwd_tab[sbox_in_rr];
  assign sbox_out_fx = sbox_inv_fx ? inv_tab[sbox_in_fx] : fwd_tab[sbox_in_fx];

  aes_v2_sbox_arbiter #(.PRIO_FIXED(1'b0)) dut_rr (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .a_valid(a_valid), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_enc(a_enc), .a_rot(a_rot),
    .a_ready(a_ready_rr), .a_rd(a_rd_rr),
    .b_valid(b_valid), .b_rs1(b_rs1), .b_rs2(b_rs2), .b_enc(b_enc), .b_rot(b_rot),
    .b_ready(b_ready_rr), .b_rd(b_rd_rr),
    .sbox_in(sbox_in_rr), .sbox_inv(sbox_inv_rr), .sbox_out(sbox_out_rr),
    .busy(busy_rr), .grant(grant_rr)
  );

  aes_v2_sbox_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .a_valid(a_valid), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_enc(a_enc), .a_rot(a_rot),
    .a_ready(a_ready_fx), .a_rd(a_rd_fx),
    .b_valid(b_valid), .b_rs1(b_rs1), .b_rs2(b_rs2), .b_enc(b_enc), .b_rot(b_rot),
    .b_ready(b_ready_fx), .b_rd(b_rd_fx),
    .sbox_in(sbox_in_fx), .sbox_inv(sbox_inv_fx), .sbox_out(sbox_out_fx),
    .busy(busy_fx), .grant(grant_fx)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    logic [7:0] a;
    r = 8'h00;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] p;
    p = 8'h01;
    if (x == 8'h00) p = 8'h00;
    else for (int i = 0; i < 254; i++) p = gmul(p, x);
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  task automatic apply_reset();
    g_resetn = 1'b1;
    a_valid = 1'b0; a_enc = 1'b0; a_rot = 1'b0; a_rs1 = '0; a_rs2 = '0;
    b_valid = 1'b0; b_enc = 1'b0; b_rot = 1'b0; b_rs1 = '0; b_rs2 = '0;
    repeat (2) @(negedge g_clk);
    g_resetn = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    g_resetn = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    a_rs1 = 32'h0102_0304; b_rs1 = 32'h0506_0708;
    repeat (2) @(negedge g_clk);
    #1;
    assert_cnt++; if (a_ready_rr !== 1'b0) begin fail_cnt++; $display("FAIL reset_a_ready: got %b, expected 0", a_ready_rr); end
    assert_cnt++; if (b_ready_rr !== 1'b0) begin fail_cnt++; $display("FAIL reset_b_ready: got %b, expected 0", b_ready_rr); end
    assert_cnt++; if (a_rd_rr !== 32'h0) begin fail_cnt++; $display("FAIL reset_a_rd: got %h, expected 0", a_rd_rr); end
    assert_cnt++; if (b_rd_rr !== 32'h0) begin fail_cnt++; $display("FAIL reset_b_rd: got %h, expected 0", b_rd_rr); end
    assert_cnt++; if (busy_rr !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b, expected 0", busy_rr); end
    assert_cnt++; if (sbox_in_rr !== 8'h00) begin fail_cnt++; $display("FAIL reset_sbox_in: got %h, expected 00", sbox_in_rr); end
    assert_cnt++; if (sbox_inv_rr !== 1'b0) begin fail_cnt++; $display("FAIL reset_sbox_inv: got %b, expected 0", sbox_inv_rr); end
    assert_cnt++; if (grant_rr !== 1'b0) begin fail_cnt++; $display("FAIL reset_grant: got %b, expected 0", grant_rr); end
    $display("test_reset: done");
  endtask

  task automatic test_single_a(input logic rot, input logic [31:0] exp_rd, input string name);
    int first, ready_cnt, busy_cnt, stray;
    logic [31:0] rd_got;
    logic [7:0] in_step0;
    first = -1; ready_cnt = 0; busy_cnt = 0; stray = 0; rd_got = '0; in_step0 = '0;
    apply_reset();
    a_rs1 = 32'h0053_0001; a_rs2 = 32'h5300_0000; a_enc = 1'b1; a_rot = rot; a_valid = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 5) a_valid = 1'b0;
      #1;
      if (a_ready_rr) begin
        ready_cnt++;
        if (first < 0) begin first = cyc; rd_got = a_rd_rr; end
      end else if (a_rd_rr !== 32'h0) stray++;
      if (b_ready_rr !== 1'b0 || b_rd_rr !== 32'h0) stray++;
      if (busy_rr) busy_cnt++;
      if (cyc == 1) in_step0 = sbox_in_rr;
      @(negedge g_clk);
    end
    assert_cnt++; if (first !== 4) begin fail_cnt++; $display("FAIL %s_latency: got %0d, expected 4", name, first); end
    assert_cnt++; if (rd_got !== exp_rd) begin fail_cnt++; $display("FAIL %s_rd: got %h, expected %h", name, rd_got, exp_rd); end
    assert_cnt++; if (ready_cnt !== 1) begin fail_cnt++; $display("FAIL %s_ready_pulses: got %0d, expected 1", name, ready_cnt); end
    assert_cnt++; if (busy_cnt !== 4) begin fail_cnt++; $display("FAIL %s_busy_cycles: got %0d, expected 4", name, busy_cnt); end
    assert_cnt++; if (stray !== 0) begin fail_cnt++; $display("FAIL %s_stray_outputs: got %0d, expected 0", name, stray); end
    assert_cnt++; if (in_step0 !== 8'h01) begin fail_cnt++; $display("FAIL %s_sbox_in_step0: got %h, expected 01", name, in_step0); end
    $display("%s: ready at cycle %0d rd=%h", name, first, rd_got);
  endtask

  task automatic test_inverse_b();
    int first, inv_bad, stray;
    logic [31:0] rd_got;
    logic exp_inv;
    first = -1; inv_bad = 0; stray = 0; rd_got = 32'hFFFF_FFFF;
    apply_reset();
    b_rs1 = 32'h6363_6363; b_rs2 = 32'h6363_6363; b_enc = 1'b0; b_valid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 5) b_valid = 1'b0;
      #1;
      exp_inv = (cyc >= 1 && cyc <= 4);
      if (sbox_inv_rr !== exp_inv) inv_bad++;
      if (b_ready_rr && first < 0) begin first = cyc; rd_got = b_rd_rr; end
      if (a_ready_rr !== 1'b0) stray++;
      @(negedge g_clk);
    end
    assert_cnt++; if (first !== 4) begin fail_cnt++; $display("FAIL inv_b_latency: got %0d, expected 4", first); end
    assert_cnt++; if (rd_got !== 32'h0000_0000) begin fail_cnt++; $display("FAIL inv_b_rd: got %h, expected 00000000", rd_got); end
    assert_cnt++; if (inv_bad !== 0) begin fail_cnt++; $display("FAIL inv_b_sbox_inv: got %0d bad cycles, expected 0", inv_bad); end
    assert_cnt++; if (grant_rr !== 1'b1) begin fail_cnt++; $display("FAIL inv_b_grant_hold: got %b, expected 1", grant_rr); end
    assert_cnt++; if (stray !== 0) begin fail_cnt++; $display("FAIL inv_b_a_ready: got %0d pulses, expected 0", stray); end
    $display("test_inverse_b: ready at cycle %0d rd=%h", first, rd_got);
  endtask

  task automatic run_contention(output logic [31:0] a_mask_rr, output logic [31:0] b_mask_rr,
                                output logic [31:0] a_mask_fx, output logic [31:0] b_mask_fx,
                                output int rd_bad, output int both, output logic grant6);
    a_mask_rr = '0; b_mask_rr = '0; a_mask_fx = '0; b_mask_fx = '0;
    rd_bad = 0; both = 0; grant6 = 1'b0;
    apply_reset();
    a_enc = 1'b1; b_enc = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    for (int cyc = 0; cyc < 22; cyc++) begin
      #1;
      if (a_ready_rr) begin a_mask_rr[cyc] = 1'b1; if (a_rd_rr !== 32'h6363_6363) rd_bad++; end
      if (b_ready_rr) begin b_mask_rr[cyc] = 1'b1; if (b_rd_rr !== 32'h6363_6363) rd_bad++; end
      if (a_ready_fx) begin a_mask_fx[cyc] = 1'b1; if (a_rd_fx !== 32'h6363_6363) rd_bad++; end
      if (b_ready_fx) b_mask_fx[cyc] = 1'b1;
      if ((a_ready_rr && b_ready_rr) || (a_ready_fx && b_ready_fx)) both++;
      if (cyc == 6) grant6 = grant_rr;
      @(negedge g_clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] am, bm, afx, bfx;
    int rd_bad, both;
    logic g6;
    run_contention(am, bm, afx, bfx, rd_bad, both, g6);
    assert_cnt++; if (am !== 32'h0000_4010) begin fail_cnt++; $display("FAIL rr_a_ready_cycles: got %h, expected 00004010", am); end
    assert_cnt++; if (bm !== 32'h0008_0200) begin fail_cnt++; $display("FAIL rr_b_ready_cycles: got %h, expected 00080200", bm); end
    assert_cnt++; if (rd_bad !== 0) begin fail_cnt++; $display("FAIL rr_rd_values: got %0d bad, expected 0", rd_bad); end
    assert_cnt++; if (both !== 0) begin fail_cnt++; $display("FAIL rr_dual_ready: got %0d, expected 0", both); end
    assert_cnt++; if (g6 !== 1'b1) begin fail_cnt++; $display("FAIL rr_grant_after_a: got %b, expected 1", g6); end
    $display("test_round_robin: a_mask=%h b_mask=%h", am, bm);
  endtask

  task automatic test_prio_fixed();
    logic [31:0] am, bm, afx, bfx;
    int rd_bad, both;
    logic g6;
    run_contention(am, bm, afx, bfx, rd_bad, both, g6);
    assert_cnt++; if (afx !== 32'h0008_4210) begin fail_cnt++; $display("FAIL fixed_a_ready_cycles: got %h, expected 00084210", afx); end
    assert_cnt++; if (bfx !== 32'h0000_0000) begin fail_cnt++; $display("FAIL fixed_b_ready_cycles: got %h, expected 00000000", bfx); end
    $display("test_prio_fixed: a_mask=%h b_mask=%h", afx, bfx);
  endtask

  task automatic test_abort();
    int a_cnt, b_first, b_cnt, a_first, busy4;
    logic [31:0] rd_got;
    a_cnt = 0; b_first = -1; b_cnt = 0; a_first = -1; busy4 = -1; rd_got = '0;
    apply_reset();
    a_enc = 1'b1; a_valid = 1'b1;
    b_rs1 = 32'h0053_0001; b_rs2 = 32'h5300_0000; b_enc = 1'b1; b_valid = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc == 3) a_valid = 1'b0;
      if (cyc == 9) b_valid = 1'b0;
      #1;
      if (a_ready_rr) a_cnt++;
      if (b_ready_rr && b_first < 0) begin b_first = cyc; rd_got = b_rd_rr; end
      if (cyc == 4) busy4 = int'(busy_rr);
      @(negedge g_clk);
    end
    assert_cnt++; if (a_cnt !== 0) begin fail_cnt++; $display("FAIL abort_a_ready: got %0d pulses, expected 0", a_cnt); end
    assert_cnt++; if (busy4 !== 0) begin fail_cnt++; $display("FAIL abort_idle_busy: got %0d, expected 0", busy4); end
    assert_cnt++; if (b_first !== 8) begin fail_cnt++; $display("FAIL abort_b_latency: got %0d, expected 8", b_first); end
    assert_cnt++; if (rd_got !== 32'hEDED_637C) begin fail_cnt++; $display("FAIL abort_b_rd: got %h, expected eded637c", rd_got); end
    // Second phase: an aborted A must not consume its fairness turn.
    apply_reset();
    a_enc = 1'b1; b_enc = 1'b1; a_valid = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc == 3) a_valid = 1'b0;
      if (cyc == 5) begin a_valid = 1'b1; b_valid = 1'b1; end
      if (cyc == 10) a_valid = 1'b0;
      #1;
      if (a_ready_rr && a_first < 0) a_first = cyc;
      if (b_ready_rr) b_cnt++;
      @(negedge g_clk);
    end
    b_valid = 1'b0;
    assert_cnt++; if (a_first !== 9) begin fail_cnt++; $display("FAIL abort_last_grant_kept: got %0d, expected 9", a_first); end
    assert_cnt++; if (b_cnt !== 0) begin fail_cnt++; $display("FAIL abort_b_early: got %0d pulses, expected 0", b_cnt); end
    $display("test_abort: b ready at %0d rd=%h, a regrant ready at %0d", b_first, rd_got, a_first);
  endtask

  task automatic test_reset_mid();
    int busy2, b_first, early;
    logic [7:0] in3;
    logic inv3, grant3, busy3, ready3;
    logic [31:0] rd3;
    busy2 = -1; b_first = -1; early = 0;
    in3 = 8'hFF; inv3 = 1'b1; grant3 = 1'b1; busy3 = 1'b1; ready3 = 1'b1; rd3 = 32'hFFFF_FFFF;
    apply_reset();
    b_rs1 = 32'h6363_6363; b_rs2 = 32'h6363_6363; b_enc = 1'b0; b_valid = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      if (cyc == 2) g_resetn = 1'b1;
      if (cyc == 4) g_resetn = 1'b0;
      if (cyc == 10) b_valid = 1'b0;
      #1;
      if (cyc == 2) busy2 = int'(busy_rr);
      if (cyc == 3) begin
        in3 = sbox_in_rr; inv3 = sbox_inv_rr; grant3 = grant_rr;
        busy3 = busy_rr; ready3 = b_ready_rr; rd3 = b_rd_rr;
      end
      if (b_ready_rr && b_first < 0) begin
        b_first = cyc;
        if (cyc < 8) early++;
      end
      @(negedge g_clk);
    end
    assert_cnt++; if (busy2 !== 1) begin fail_cnt++; $display("FAIL rst_mid_busy_before: got %0d, expected 1", busy2); end
    assert_cnt++; if (busy3 !== 1'b0) begin fail_cnt++; $display("FAIL rst_mid_busy: got %b, expected 0", busy3); end
    assert_cnt++; if (in3 !== 8'h00) begin fail_cnt++; $display("FAIL rst_mid_sbox_in: got %h, expected 00", in3); end
    assert_cnt++; if (inv3 !== 1'b0) begin fail_cnt++; $display("FAIL rst_mid_sbox_inv: got %b, expected 0", inv3); end
    assert_cnt++; if (grant3 !== 1'b0) begin fail_cnt++; $display("FAIL rst_mid_grant: got %b, expected 0", grant3); end
    assert_cnt++; if (ready3 !== 1'b0 || rd3 !== 32'h0) begin fail_cnt++; $display("FAIL rst_mid_b_out: got ready=%b rd=%h, expected ready=0 rd=0", ready3, rd3); end
    assert_cnt++; if (b_first !== 8 || early !== 0) begin fail_cnt++; $display("FAIL rst_mid_rerequest: got %0d, expected 8", b_first); end
    $display("test_reset_mid: re-request ready at cycle %0d", b_first);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      fwd_tab[i] = sbox_fwd(8'(i));
      inv_tab[fwd_tab[i]] = 8'(i);
    end
    g_resetn = 1'b1;
    test_reset();
    test_single_a(1'b0, 32'hEDED_637C, "fwd_a_rot0");
    test_single_a(1'b1, 32'hED63_7CED, "fwd_a_rot1");
    test_inverse_b();
    test_round_robin();
    test_prio_fixed();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/aes_v2_sbox_arbiter.md
Name: aes_v2_sbox_arbiter

Overview:
Shares one combinational AES S-box between two word-level SubBytes requesters, port A and port B (e.g. the SubBytes instruction path and the key-schedule path).
The block arbitrates between the ports, then sequences the four byte lookups of the granted word through the external S-box instance.
It assembles the 32-bit result and returns it to the granted requester with a ready pulse.
Byte selection and result packing match the lightweight sub-size SubBytes semantics, so each requester sees identical results.

Parameters:
PRIO_FIXED, 0, 0 = round-robin between A and B; 1 = port A always wins contention.

Ports:
g_clk      in   1   clock
g_resetn   in   1   reset, synchronous, active-high (asserted = 1 resets the block)
a_valid    in   1   port A request; held with operands stable until a_ready
a_rs1      in   32  port A source 1
a_rs2      in   32  port A source 2
a_enc      in   1   port A forward (1) / inverse (0) S-box
a_rot      in   1   port A rotated result packing
a_ready    out  1   port A result valid, single-cycle pulse
a_rd       out  32  port A result; 0 when a_ready=0
b_valid, b_rs1, b_rs2, b_enc, b_rot, b_ready, b_rd: same as port A, for port B
sbox_in    out  8   byte to external S-box
sbox_inv   out  1   inverse select to external S-box
sbox_out   in   8   external S-box result (combinational, same cycle)
busy       out  1   1 while in RUN
grant      out  1   current owner: 0 = A, 1 = B; holds its last value in IDLE

Behaviour:
- Registers: state {IDLE, RUN}, step[1:0], grant, last_grant, b0/b1/b2[7:0].
- Reset values: state=IDLE, step=0, grant=0, last_grant=1 (so A wins the first contention), b0..b2=0.
- Reset output values: a_ready=b_ready=0, a_rd=b_rd=0, busy=0, sbox_in=0, sbox_inv=0.
- Reset mid-operation: takes effect next edge; the request is aborted with no ready. The requester must re-present its request after reset.
- IDLE: if any valid, register grant and go to RUN with step=0.
  - Only one port valid: grant that port.
  - Both valid: grant !last_grant when PRIO_FIXED=0; grant A when PRIO_FIXED=1.
- RUN step byte selection, from the granted port's operands:
  - step 0: rs1[7:0]
  - step 1: rs2[15:8]
  - step 2: rs1[23:16]
  - step 3: rs2[31:24]
- RUN datapath:
  - sbox_inv = !enc of the granted port.
  - sbox_out is captured into b0, b1, b2 at steps 0, 1, 2.
  - step increments each cycle.
- RUN step 3:
  - Granted ready=1 for that cycle.
  - rd = rot ? {b2,b1,b0,sbox_out} : {sbox_out,b2,b1,b0}.
  - Next state: last_grant<=grant, state<=IDLE.
- Latency: request seen in IDLE at cycle t gives ready at cycle t+4. One IDLE cycle separates jobs, so back-to-back ready pulses are 5 cycles apart.
- Abort: if the granted port drops valid during RUN, return to IDLE next edge, with no ready and last_grant unchanged.
- Non-granted port: may assert or drop valid freely; its ready and rd stay 0.
- Operand changes mid-RUN are not permitted; the result is undefined if they occur.
- Outside RUN: sbox_in=0 and sbox_inv=0.
- Requester obligation: after ready the requester drops valid or presents a new request. A valid still high in the following IDLE cycle is treated as a new request.
- Ready never asserts on both ports in the same cycle.

Test Plan:
- Reset, then A: valid, enc=1, rot=0, rs1=0x00530001, rs2=0x53000000 -> a_ready at cycle 4, a_rd=0xEDED637C; b_ready stays 0.
- Same operands with rot=1 -> a_rd=0xED637CED.
- B: enc=0, rs1=rs2=0x63636363 -> b_ready at cycle 4, b_rd=0x00000000, sbox_inv=1 throughout RUN.
- A and B both valid from reset with all-zero operands, enc=1, PRIO_FIXED=0:
  - a_ready at cycle 4 with a_rd=0x63636363; b_ready at cycle 9 with b_rd=0x63636363.
  - A then re-requests while B is still valid -> B's second request is not starved; grants alternate.
- PRIO_FIXED=1 with both ports continuously valid -> only A is granted; b_ready never asserts.
- Abort and reset mid-job:
  - A drops valid at step 2 -> no ready, back to IDLE; a pending B is granted next, since last_grant was not updated.
  - g_resetn=1 asserted at step 1 -> all outputs 0 next cycle, state IDLE.
